// File: rtl/mips_pipe_pkg.sv
// Shared pipeline-register types: occupancy-state encoding and the per-entry
// header record (valid + control bits) reused by all MIPS stage registers.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
  } pipe_ctrl_t;

  // Data payload width differs per stage, so it travels beside this record.
  typedef struct packed {
    logic       valid;
    pipe_ctrl_t ctrl;
  } pipe_entry_hdr_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: header (valid + control) and a data payload.
// clear drops only the valid bit, load captures header and payload together.
module pipe_entry_reg
  import mips_pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 69
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clear,
  input  pipe_entry_hdr_t      hdr_d,
  input  logic [PAYLOAD_W-1:0] payload_d,
  output pipe_entry_hdr_t      hdr_q,
  output logic [PAYLOAD_W-1:0] payload_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_q     <= '0;
      payload_q <= '0;
    end else if (clear) begin
      hdr_q.valid <= 1'b0;
    end else if (load) begin
      hdr_q     <= hdr_d;
      payload_q <= payload_d;
    end
  end

endmodule

// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register with a one-entry skid buffer so in_ready is
// registered and never depends combinationally on out_ready.
module exe_mem_skid_reg
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  WB_EN_in,
  input  logic                  MEM_R_EN_in,
  input  logic                  MEM_W_EN_in,
  input  logic [DATA_W-1:0]     ALU_Res_in,
  input  logic [DATA_W-1:0]     ST_Val_in,
  input  logic [REG_ADDR_W-1:0] Dest_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  WB_EN,
  output logic                  MEM_R_EN,
  output logic                  MEM_W_EN,
  output logic [DATA_W-1:0]     ALU_Res,
  output logic [DATA_W-1:0]     ST_Val,
  output logic [REG_ADDR_W-1:0] Dest,
  output logic [1:0]            occupancy,
  output pipe_state_e           state_dbg
);

  localparam int PAYLOAD_W = 2 * DATA_W + REG_ADDR_W;

  // Handshake: a beat moves on a rising edge where valid and ready are both 1.
  // in_ready is a flop; out_valid follows MAIN's valid bit.
  pipe_state_e           state, state_next;
  pipe_entry_hdr_t       in_hdr, main_hdr_d, main_hdr_q, skid_hdr_q;
  logic [PAYLOAD_W-1:0]  in_payload, main_payload_d, main_payload_q, skid_payload_q;
  logic                  main_load, main_clear, skid_load, skid_clear, main_from_skid;
  logic                  xfer_in, xfer_out;

  assign xfer_in  = in_valid & in_ready;
  assign xfer_out = out_valid & out_ready;

  always_comb begin
    in_hdr.valid         = 1'b1;
    in_hdr.ctrl.wb_en    = WB_EN_in;
    in_hdr.ctrl.mem_r_en = MEM_R_EN_in;
    in_hdr.ctrl.mem_w_en = MEM_W_EN_in;
  end

  assign in_payload     = {ALU_Res_in, ST_Val_in, Dest_in};
  assign main_hdr_d     = main_from_skid ? skid_hdr_q     : in_hdr;
  assign main_payload_d = main_from_skid ? skid_payload_q : in_payload;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != ST_TWO);
    end
  end

  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_next = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (xfer_in) begin
            main_load  = 1'b1;
            state_next = ST_ONE;
          end
        end
        ST_ONE: begin
          case ({xfer_in, xfer_out})
            2'b10: begin
              skid_load  = 1'b1;
              state_next = ST_TWO;
            end
            2'b01: begin
              main_clear = 1'b1;
              state_next = ST_EMPTY;
            end
            2'b11: main_load = 1'b1;
            default: ;
          endcase
        end
        ST_TWO: begin
          if (xfer_out) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_next     = ST_ONE;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
          state_next = ST_EMPTY;
        end
      endcase
    end
  end

  pipe_entry_reg #(.PAYLOAD_W(PAYLOAD_W)) u_main (
    .clk       (clk),
    .rst       (rst),
    .load      (main_load),
    .clear     (main_clear),
    .hdr_d     (main_hdr_d),
    .payload_d (main_payload_d),
    .hdr_q     (main_hdr_q),
    .payload_q (main_payload_q)
  );

  pipe_entry_reg #(.PAYLOAD_W(PAYLOAD_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .clear     (skid_clear),
    .hdr_d     (in_hdr),
    .payload_d (in_payload),
    .hdr_q     (skid_hdr_q),
    .payload_q (skid_payload_q)
  );

  // MAIN keeps stale control bits after it empties, hence the gating.
  assign out_valid = main_hdr_q.valid;
  assign WB_EN     = main_hdr_q.ctrl.wb_en    & out_valid;
  assign MEM_R_EN  = main_hdr_q.ctrl.mem_r_en & out_valid;
  assign MEM_W_EN  = main_hdr_q.ctrl.mem_w_en & out_valid;
  assign {ALU_Res, ST_Val, Dest} = main_payload_q;
  assign occupancy = state;
  assign state_dbg = state;

endmodule

// File: doc/exe_mem_skid_reg.md
EXE_MEM_SKID_REG -- requirements
Module: exe_mem_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of ALU result and store value.
REQ-002 Parameter REG_ADDR_W, default 5, width of destination register index.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port flush  input  1  discard all held entries (branch/exception squash).
REQ-006 Port in_valid  input  1  EXE stage presents an instruction.
REQ-007 Port in_ready  output  1  stage can accept; registered, no combinational path from out_ready.
REQ-008 Port WB_EN_in, MEM_R_EN_in, MEM_W_EN_in  input  1 each  control bits from EXE.
REQ-009 Port ALU_Res_in, ST_Val_in  input  DATA_W each  EXE results.
REQ-010 Port Dest_in  input  REG_ADDR_W  destination register.
REQ-011 Port out_valid  output  1  MEM stage entry valid.
REQ-012 Port out_ready  input  1  MEM stage accepts (low = memory stall).
REQ-013 Port WB_EN, MEM_R_EN, MEM_W_EN  output  1 each  control bits, forced 0 when out_valid=0.
REQ-014 Port ALU_Res, ST_Val  output  DATA_W each; Dest  output  REG_ADDR_W.
REQ-015 Port occupancy  output  2  number of held entries, 0..2.

Function
REQ-016 Storage SHALL be two entries: MAIN (drives outputs) and SKID (overflow), each holding valid, three control bits, ALU_Res, ST_Val, Dest.
REQ-017 State machine SHALL have states EMPTY (none valid), ONE (MAIN valid), TWO (MAIN and SKID valid).
REQ-018 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-019 EMPTY: transfer in -> load MAIN, go ONE; else stay.
REQ-020 ONE: in only -> load SKID, go TWO; out only -> go EMPTY; in and out -> load MAIN with new data, stay ONE.
REQ-021 TWO: out -> move SKID to MAIN, go ONE; no out -> hold everything.
REQ-022 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, registered from next-state.
REQ-023 out_valid SHALL be 1 exactly in ONE and TWO; outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 Latency: data accepted at edge N SHALL appear on outputs after edge N when stage was EMPTY, zero bubbles at full throughput.
REQ-025 Order SHALL be preserved: no entry overtakes another.
REQ-026 flush=1 SHALL at the next edge clear both valids, go EMPTY, in_ready=1; in_valid that cycle is dropped; flush has priority over all transfers.
REQ-027 Control outputs SHALL be gated: WB_EN=MAIN.WB_EN & out_valid (same for MEM_R_EN, MEM_W_EN); data outputs need not be zeroed when invalid.
REQ-028 occupancy SHALL equal 0/1/2 for EMPTY/ONE/TWO.

Reset
REQ-029 rst=1 SHALL asynchronously force EMPTY, both valids 0, all control, data and Dest registers 0, occupancy 0.
REQ-030 in_ready SHALL be 0 during rst and 1 from the first edge after rst deasserts.
REQ-031 rst mid-operation SHALL discard held entries without any output transfer.

Structure
REQ-032 State encoding (EMPTY/ONE/TWO) and the entry record type SHALL live in shared package mips_pipe_pkg, reused by other stage registers.
REQ-033 One sub-module pipe_entry_reg (single entry: load enable, clear, payload) SHALL be instantiated twice for MAIN and SKID.

Verification
REQ-034 Reset: assert rst mid-stream with 2 entries held -> outputs 0, occupancy 0, in_ready 1 one edge after release.
REQ-035 Streaming: out_ready=1, 8 back-to-back inputs ALU_Res=1..8 -> outputs 1..8 on consecutive cycles, occupancy stays 1.
REQ-036 Stall: out_ready=0, push ALU_Res=0xA, 0xB -> occupancy 2, in_ready 0, outputs hold 0xA; raise out_ready -> 0xA then 0xB emitted.
REQ-037 Flush: occupancy 2 with MEM_W_EN=1 entries, flush=1 with in_valid=1 -> next cycle out_valid 0, MEM_W_EN 0, occupancy 0, flushed input never emitted.
REQ-038 Gating: out_valid=0 with stale MAIN WB_EN=1 -> WB_EN output 0.
REQ-039 Random: random in_valid/out_ready/flush for 10k cycles -> scoreboard order and content match, no loss or duplication.
